// File: rtl/enc_pkg.sv
// enc_pkg: shared constants, FSM state type and encoding helpers for dec_to_bcd_key_encoder
//   NUM_KEYS       number of decimal key lines (digits 0..9)
//   BCD_W          width of the emitted BCD code
//   state_t        IDLE / DEBOUNCE / HELD press-tracking states
//   prio_enc       highest set key index, zero-extended to BCD_W
//   onehot_or_zero true when at most one key line is set
package enc_pkg;
  localparam int NUM_KEYS = 10;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
  function automatic logic [BCD_W-1:0] prio_enc(input logic [NUM_KEYS-1:0] v);
    prio_enc = '0;
    for (int i = 0; i < NUM_KEYS; i++) prio_enc = v[i] ? BCD_W'(i) : prio_enc;
  endfunction
  function automatic logic onehot_or_zero(input logic [NUM_KEYS-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser plus stability counter for a bus of raw key lines
//   clk, rst  clock and asynchronous active-high reset
//   din       raw asynchronous lines
//   s         synchronised lines (second flop stage)
//   stable    one-cycle pulse when s has held the same value for DEBOUNCE_CYCLES samples
module key_debouncer #(
  parameter int W = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] s,
  output logic         stable
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [W-1:0] meta, prev;
  logic [CNT_W-1:0] cnt;
  logic hit, same;
  assign same = s == prev;
  // hit remembers that this run already produced its pulse, so the counter can saturate
  assign stable = same && cnt == LAST && !hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      s <= '0;
      prev <= '0;
      cnt <= '0;
      hit <= 1'b0;
    end else begin
      meta <= din;
      s <= meta;
      prev <= s;
      cnt <= !same ? '0 : cnt == LAST ? cnt : cnt + 1'b1;
      hit <= !same ? 1'b0 : cnt == LAST ? 1'b1 : hit;
    end
  end
endmodule

// File: rtl/dec_to_bcd_key_encoder.sv
// dec_to_bcd_key_encoder: debounces ten decimal key lines and emits each press once as BCD over valid/ready
//   clk, rst   clock and asynchronous active-high reset
//   keys       raw key lines, bit i = digit i
//   bcd        code of the accepted key, held while bcd_valid & !bcd_ready
//   bcd_valid  bcd holds an unconsumed code
//   bcd_ready  consumer takes bcd this cycle
//   ovf        sticky flag: a press was dropped because the previous code was unconsumed
//   clr_ovf    synchronous clear of ovf (a simultaneous drop wins)
//   err        one-cycle pulse on a multi-key accept, only when MULTI_KEY_ERR_EN is defined
module dec_to_bcd_key_encoder
  import enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys,
  output logic [3:0] bcd,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic       ovf,
  input  logic       clr_ovf
`ifdef MULTI_KEY_ERR_EN
  ,
  output logic       err
`endif
);
  state_t state;
  logic [NUM_KEYS-1:0] s;
  logic stable, accept, multi, emit, load;
  key_debouncer #(
    .W(NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_deb (
    .clk(clk),
    .rst(rst),
    .din(keys),
    .s(s),
    .stable(stable)
  );
`ifdef MULTI_KEY_ERR_EN
  assign multi = !onehot_or_zero(s);
`else
  assign multi = 1'b0;
`endif
  assign accept = state == DEBOUNCE && s != '0 && stable;
  assign emit = accept && !multi;
  // the slot is free if empty or being drained on this very edge
  assign load = emit && (!bcd_valid || bcd_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bcd <= '0;
      bcd_valid <= 1'b0;
      ovf <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
      err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:     state <= s != '0 ? DEBOUNCE : IDLE;
        DEBOUNCE: state <= s == '0 ? IDLE : stable ? HELD : DEBOUNCE;
        HELD:     state <= s == '0 && stable ? IDLE : HELD;
        default:  state <= IDLE;
      endcase
      bcd <= load ? prio_enc(s) : bcd;
      bcd_valid <= load || (bcd_valid && !bcd_ready);
      ovf <= (emit && !load) || (ovf && !clr_ovf);
`ifdef MULTI_KEY_ERR_EN
      err <= accept && multi;
`endif
    end
  end
endmodule

// File: doc/dec_to_bcd_key_encoder.md
Name: dec_to_bcd_key_encoder

Overview:
Encodes ten decimal key lines (digits 0-9) into a 4-bit BCD code. This is the inverse of the BCD-to-decimal one-hot decoder.
Raw asynchronous key lines are synchronised, debounced, and priority-encoded. Each press is emitted exactly once as a BCD word through a valid/ready handshake.
The block sits between the keypad pins and the digit datapath or display logic.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a press or a release (legal range 2..65535).
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
clk  input  1  single clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
keys  input  10  raw key lines, bit i = digit i, active-high, asynchronous.
bcd  output  4  BCD code of accepted key, 0..9.
bcd_valid  output  1  bcd holds an unconsumed code.
bcd_ready  input  1  consumer accepts bcd this cycle.
ovf  output  1  sticky: a press was dropped because the previous code was unconsumed.
clr_ovf  input  1  synchronous clear of ovf.
err  output  1  present only with MULTI_KEY_ERR_EN (see below).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - bcd=0, bcd_valid=0, ovf=0, err=0.
  - Synchroniser flops = 0, counter = 0, FSM = IDLE.
- Synchroniser: two flops per key; s = second stage.
- Debounce:
  - Counter restarts at 0 whenever s differs from the previous sample.
  - A pattern is "stable" when the counter reaches DEBOUNCE_CYCLES-1 with s unchanged.
- FSM states: IDLE, DEBOUNCE, HELD.
  - IDLE: s!=0 -> DEBOUNCE (counter=0).
  - DEBOUNCE:
    - s==0 -> IDLE.
    - s changed -> stay, counter restarts.
    - stable -> accept; -> HELD.
  - HELD:
    - Waits for s==0 stable for DEBOUNCE_CYCLES -> IDLE.
    - Any nonzero s in HELD (extra or different keys) restarts the release count and never produces a code.
- Encoding: highest set index wins, e.g. keys=10'b00_0010_0100 -> 5. Result zero-extended, always 0..9.
- Accept action:
  - If bcd_valid=0, or bcd_valid&bcd_ready in the same cycle: load bcd and set bcd_valid on the next edge.
  - Otherwise: drop the code, set ovf, leave bcd and bcd_valid unchanged.
- Latency: keys stable from edge N -> bcd_valid high after edge N+2+DEBOUNCE_CYCLES.
- Handshake:
  - bcd is held constant while bcd_valid&!bcd_ready.
  - Transfer on bcd_valid&bcd_ready; bcd_valid clears on that edge unless a simultaneous accept reloads it.
  - bcd_ready is ignored when bcd_valid=0.
- ovf: set on a drop, cleared by clr_ovf; set wins over a simultaneous clr_ovf.
- Reset mid-operation:
  - All state is cleared asynchronously, and any pending code is lost.
  - A key still held at reset release is debounced and emitted as a new press.

Optional Feature:
MULTI_KEY_ERR_EN:
- Defined:
  - An accepted pattern with more than one bit set emits no code and enters HELD.
  - err pulses high for exactly one cycle on the accept edge.
  - ovf is not affected.
- Undefined: port err is absent and multi-key patterns are priority-encoded (highest index).

Decomposition:
- Package enc_pkg:
  - NUM_KEYS=10, BCD_W=4.
  - Enum state_t {IDLE, DEBOUNCE, HELD}.
  - Function prio_enc(logic [9:0]) -> logic [3:0].
  - Function onehot_or_zero(logic [9:0]) used by MULTI_KEY_ERR_EN.
- Sub-module key_debouncer:
  - Parameterised by width and DEBOUNCE_CYCLES.
  - Contains the synchronisers and the stability counter.
  - Outputs s and a one-cycle stable pulse.
- The top level holds the FSM, encoder, output register and handshake.

Test Plan (DEBOUNCE_CYCLES=4):
- keys=10'h008 held 20 cycles, bcd_ready=1 -> bcd=3, bcd_valid high exactly 1 cycle, 6 edges after keys applied; no second code while held.
- keys toggles 0x001/0x000 every 2 cycles for 20 cycles, then 0x200 stable -> no code during the bounce; then a single bcd=9.
- bcd_ready=0; press 7, release, press 2 -> bcd stays 7 with valid high, ovf=1; bcd_ready=1 -> 7 transferred; clr_ovf -> ovf=0.
- Code 4 pending and bcd_ready asserted on the same edge a press of 6 is accepted -> 4 transferred, bcd=6 next cycle, bcd_valid stays 1, ovf=0.
- keys=10'h024 stable -> without macro bcd=5; with MULTI_KEY_ERR_EN err one-cycle pulse and no bcd_valid.
- rst asserted mid-DEBOUNCE and again while bcd_valid=1 -> outputs 0 immediately (asynchronous); a key held through reset release produces one code after 2+4 edges.
